// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states,
// bus size codes and the latched request record.
package mem_port_arbiter_pkg;

  localparam int REQ_ADDR_W = 64;
  localparam int REQ_DATA_W = 64;
  localparam int REQ_STRB_W = REQ_DATA_W / 8;

  // Size codes follow the common msize encoding (log2 of the byte count)
  localparam logic [2:0] MSIZE1 = 3'b000;
  localparam logic [2:0] MSIZE2 = 3'b001;
  localparam logic [2:0] MSIZE4 = 3'b010;
  localparam logic [2:0] MSIZE8 = 3'b011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [REQ_ADDR_W-1:0] addr;
    logic [2:0]            size;
    logic [REQ_STRB_W-1:0] strobe;
    logic [REQ_DATA_W-1:0] data;
  } mem_req_t;

  // Fetch returns a 32-bit word picked out of the 64-bit beat by address bit 2
  function automatic logic [31:0] select_word(input logic [REQ_DATA_W-1:0] rdata,
                                              input logic                  upper);
    select_word = upper ? rdata[63:32] : rdata[31:0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and shared-bus signals of the memory port arbiter.
// The arbiter uses the slave view; core and bus bridge use the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  localparam int STRB_W = DATA_W / 8;

  logic              i_valid;
  logic [ADDR_W-1:0] i_addr;
  logic              i_data_ok;
  logic [31:0]       i_rdata;

  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic [2:0]        d_size;
  logic [STRB_W-1:0] d_strobe;
  logic [DATA_W-1:0] d_wdata;
  logic              d_data_ok;
  logic [DATA_W-1:0] d_rdata;

  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [2:0]        m_size;
  logic [STRB_W-1:0] m_strobe;
  logic [DATA_W-1:0] m_wdata;
  logic              m_data_ok;
  logic [DATA_W-1:0] m_rdata;

  logic              grant_is_d;

  modport slave (
    input  i_valid, i_addr,
    output i_data_ok, i_rdata,
    input  d_valid, d_addr, d_size, d_strobe, d_wdata,
    output d_data_ok, d_rdata,
    output m_valid, m_addr, m_size, m_strobe, m_wdata,
    input  m_data_ok, m_rdata,
    output grant_is_d
  );

  modport master (
    output i_valid, i_addr,
    input  i_data_ok, i_rdata,
    output d_valid, d_addr, d_size, d_strobe, d_wdata,
    input  d_data_ok, d_rdata,
    input  m_valid, m_addr, m_size, m_strobe, m_wdata,
    output m_data_ok, m_rdata,
    input  grant_is_d
  );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive data grants won while fetch was waiting.
module arb_starve_ctr #(
  parameter int MAX   = 4,
  parameter int CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  assign sat = (cnt == CNT_W'(MAX));

  // Clear wins over increment; the count never passes MAX
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory bus between fetch and data requesters, latching
// the winning request for the life of its transaction.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MAX_DWINS = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_DWINS + 1);

  arb_state_e        state_q;
  arb_state_e        state_d;
  mem_req_t          req_q;
  mem_req_t          req_d;
  logic              grant_i;
  logic              grant_d;
  logic              busy;
  logic              starve_inc;
  logic              starve_clr;
  logic              starve_sat;
  logic [CNT_W-1:0]  starve_cnt;
  logic              i_ok_q;
  logic              d_ok_q;
  logic [31:0]       i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              grant_is_d_q;

  assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Data wins a tie unless fetch has already lost MAX_DWINS in a row
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.d_valid && (!bus.i_valid || !starve_sat)) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
        end else if (bus.i_valid) begin
          grant_i = 1'b1;
          state_d = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.m_data_ok) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d = req_q;
    if (grant_d) begin
      req_d.valid  = 1'b1;
      req_d.addr   = REQ_ADDR_W'(bus.d_addr);
      req_d.size   = bus.d_size;
      req_d.strobe = REQ_STRB_W'(bus.d_strobe);
      req_d.data   = REQ_DATA_W'(bus.d_wdata);
    end else if (grant_i) begin
      req_d.valid  = 1'b1;
      req_d.addr   = REQ_ADDR_W'(bus.i_addr);
      req_d.size   = MSIZE4;
      req_d.strobe = '0;
      req_d.data   = '0;
    end else if (busy && bus.m_data_ok) begin
      req_d.valid  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q <= '0;
    end else begin
      req_q <= req_d;
    end
  end

  // Completion pulses last exactly the DONE cycle; read data holds until the next one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_ok_q       <= 1'b0;
      d_ok_q       <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      grant_is_d_q <= 1'b0;
    end else begin
      i_ok_q <= (state_q == BUSY_I) && bus.m_data_ok;
      d_ok_q <= (state_q == BUSY_D) && bus.m_data_ok;
      if ((state_q == BUSY_I) && bus.m_data_ok) begin
        i_rdata_q <= select_word(REQ_DATA_W'(bus.m_rdata), req_q.addr[2]);
      end
      if ((state_q == BUSY_D) && bus.m_data_ok) begin
        d_rdata_q <= bus.m_rdata;
      end
      if (grant_i || grant_d) begin
        grant_is_d_q <= grant_d;
      end
    end
  end

  assign starve_inc = grant_d && bus.i_valid;
  assign starve_clr = grant_i || (grant_d && !bus.i_valid);

  arb_starve_ctr #(
    .MAX   (MAX_DWINS),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .cnt   (starve_cnt),
    .sat   (starve_sat)
  );

  assign bus.m_valid    = req_q.valid;
  assign bus.m_addr     = req_q.addr[ADDR_W-1:0];
  assign bus.m_size     = req_q.size;
  assign bus.m_strobe   = req_q.strobe[DATA_W/8-1:0];
  assign bus.m_wdata    = req_q.data[DATA_W-1:0];
  assign bus.i_data_ok  = i_ok_q;
  assign bus.i_rdata    = i_rdata_q;
  assign bus.d_data_ok  = d_ok_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.grant_is_d = grant_is_d_q;

  // A completion outside a granted transaction is a downstream protocol error
  a_no_stray_ok: assert property (@(posedge clk) disable iff (!reset)
    bus.m_data_ok |-> busy)
    else $warning("m_data_ok received with no transaction in flight");

  a_latch_stable: assert property (@(posedge clk) disable iff (!reset)
    (busy && !bus.m_data_ok) |=> (busy && $stable(req_q)))
    else $error("granted request changed while in flight");

  a_single_ok: assert property (@(posedge clk) disable iff (!reset)
    !(i_ok_q && d_ok_q) && (starve_cnt <= CNT_W'(MAX_DWINS)))
    else $error("both completions pulsed or starvation count overflowed");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a vector table of single requests
// plus hand sequences for arbitration, starvation, reset and stray completions.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (64),
    .DATA_W    (64),
    .MAX_DWINS (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        is_d;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    logic [63:0] bus_rdata;
    logic [63:0] exp_rdata;
  } txn_t;

  typedef struct {
    logic        i_valid;
    logic [63:0] i_addr;
    logic        d_valid;
    logic [63:0] d_addr;
    logic [2:0]  d_size;
    logic [7:0]  d_strobe;
    logic [63:0] d_wdata;
    logic [63:0] bus_rdata;
    int          lat;
    logic        exp_is_d;
    logic [63:0] exp_rdata;
  } vec_t;

  txn_t        exp_q[$];
  vec_t        vecs[5];
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] last_i_rdata = '0;
  logic [63:0] last_d_rdata = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_txn(input logic is_d, input logic [63:0] addr, input logic [2:0] size,
                                   input logic [7:0] strobe, input logic [63:0] wdata,
                                   input logic [63:0] bus_rdata, input logic [63:0] exp_rdata);
    txn_t t;
    t.is_d      = is_d;
    t.addr      = addr;
    t.size      = size;
    t.strobe    = strobe;
    t.wdata     = wdata;
    t.bus_rdata = bus_rdata;
    t.exp_rdata = exp_rdata;
    exp_q.push_back(t);
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.i_valid  = v.i_valid;
    bus.i_addr   = v.i_addr;
    bus.d_valid  = v.d_valid;
    bus.d_addr   = v.d_addr;
    bus.d_size   = v.d_size;
    bus.d_strobe = v.d_strobe;
    bus.d_wdata  = v.d_wdata;
    if (v.exp_is_d)
      push_txn(1'b1, v.d_addr, v.d_size, v.d_strobe, v.d_wdata, v.bus_rdata, v.exp_rdata);
    else
      push_txn(1'b0, v.i_addr, MSIZE4, 8'h00, 64'h0, v.bus_rdata, v.exp_rdata);
  endtask

  // Waits for the next grant, checks it against the scoreboard, plays the bus
  // side with the given latency, and checks the completion pulse and hold.
  task automatic run_txn(input int lat, input bit release_req, input int exp_wait);
    txn_t e;
    int   waited = 0;
    while (!bus.m_valid && waited < 20) begin
      tick();
      waited++;
    end
    if (!bus.m_valid) begin
      checkOutput("grant_timeout", 64'(bus.m_valid), 64'h1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      checkOutput("unexpected_grant", 64'(exp_q.size()), 64'h1);
      return;
    end
    e = exp_q.pop_front();
    if (exp_wait >= 0) checkOutput("grant_latency", 64'(waited), 64'(exp_wait));
    checkOutput("grant_is_d", 64'(bus.grant_is_d), 64'(e.is_d));
    checkOutput("m_addr", bus.m_addr, e.addr);
    checkOutput("m_size", 64'(bus.m_size), 64'(e.size));
    checkOutput("m_strobe", 64'(bus.m_strobe), 64'(e.strobe));
    checkOutput("m_wdata", bus.m_wdata, e.wdata);
    if (e.is_d) begin
      bus.d_addr  = bus.d_addr ^ 64'h300;
      bus.d_wdata = ~bus.d_wdata;
    end else begin
      bus.i_addr  = bus.i_addr ^ 64'h300;
    end
    repeat (lat) begin
      tick();
      checkOutput("m_valid_held", 64'(bus.m_valid), 64'h1);
      checkOutput("m_addr_stable", bus.m_addr, e.addr);
    end
    bus.m_data_ok = 1'b1;
    bus.m_rdata   = e.bus_rdata;
    tick();
    bus.m_data_ok = 1'b0;
    bus.m_rdata   = 64'hBAD0_BAD0_BAD0_BAD0;
    checkOutput("m_valid_drop", 64'(bus.m_valid), 64'h0);
    if (e.is_d) begin
      last_d_rdata = e.exp_rdata;
      checkOutput("d_data_ok", 64'(bus.d_data_ok), 64'h1);
      checkOutput("i_data_ok_quiet", 64'(bus.i_data_ok), 64'h0);
    end else begin
      last_i_rdata = e.exp_rdata[31:0];
      checkOutput("i_data_ok", 64'(bus.i_data_ok), 64'h1);
      checkOutput("d_data_ok_quiet", 64'(bus.d_data_ok), 64'h0);
    end
    checkOutput("d_rdata", bus.d_rdata, last_d_rdata);
    checkOutput("i_rdata", 64'(bus.i_rdata), 64'(last_i_rdata));
    if (release_req) begin
      if (e.is_d) bus.d_valid = 1'b0;
      else        bus.i_valid = 1'b0;
    end
    tick();
    checkOutput("ok_pulse_end", 64'({bus.i_data_ok, bus.d_data_ok}), 64'h0);
    checkOutput("rdata_hold", {bus.i_rdata, bus.d_rdata[31:0]}, {last_i_rdata, last_d_rdata[31:0]});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 64'h8000_0004, 1'b0, 64'h0, 3'b000, 8'h00, 64'h0,
                64'h1111_2222_3333_4444, 2, 1'b0, 64'h1111_2222};
    vecs[1] = '{1'b0, 64'h0, 1'b1, 64'h8000_1000, 3'b011, 8'h00, 64'h0,
                64'h0123_4567_89AB_CDEF, 0, 1'b1, 64'h0123_4567_89AB_CDEF};
    vecs[2] = '{1'b1, 64'h8000_0008, 1'b0, 64'h0, 3'b000, 8'h00, 64'h0,
                64'hAAAA_BBBB_CCCC_DDDD, 1, 1'b0, 64'hCCCC_DDDD};
    vecs[3] = '{1'b0, 64'h0, 1'b1, 64'h100, 3'b011, 8'hFF, 64'h5555_6666_7777_8888,
                64'h0000_0000_0000_0000, 3, 1'b1, 64'h0};
    vecs[4] = '{1'b0, 64'h0, 1'b1, 64'h2008, 3'b010, 8'h0F, 64'hCAFE_F00D,
                64'hFEED_FACE_0000_0001, 1, 1'b1, 64'hFEED_FACE_0000_0001};

    reset         = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_addr    = '0;
    bus.d_valid   = 1'b0;
    bus.d_addr    = '0;
    bus.d_size    = '0;
    bus.d_strobe  = '0;
    bus.d_wdata   = '0;
    bus.m_data_ok = 1'b0;
    bus.m_rdata   = '0;
    #12;
    checkOutput("reset_m_bus", {bus.m_addr[59:0], bus.m_valid, bus.m_size}, 64'h0);
    checkOutput("reset_m_data", {bus.m_wdata[55:0], bus.m_strobe}, 64'h0);
    checkOutput("reset_oks", 64'({bus.i_data_ok, bus.d_data_ok, bus.grant_is_d}), 64'h0);
    checkOutput("reset_rdata", {bus.i_rdata, bus.d_rdata[31:0]}, 64'h0);
    checkOutput("reset_starve", 64'(dut.starve_cnt), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // Single-requester vectors, including the held-latch case at 0x100
    for (int n = 0; n < 5; n++) begin
      applyStimulus(vecs[n]);
      run_txn(vecs[n].lat, 1'b1, 1);
    end

    // Simultaneous requests: data first, then fetch after the DONE bubble
    bus.i_valid  = 1'b1;
    bus.i_addr   = 64'h8000_0010;
    bus.d_valid  = 1'b1;
    bus.d_addr   = 64'h8000_1000;
    bus.d_size   = MSIZE8;
    bus.d_strobe = 8'hFF;
    bus.d_wdata  = 64'hDEAD_BEEF;
    push_txn(1'b1, 64'h8000_1000, MSIZE8, 8'hFF, 64'hDEAD_BEEF, 64'h0BAD_F00D_0000_0042, 64'h0BAD_F00D_0000_0042);
    push_txn(1'b0, 64'h8000_0010, MSIZE4, 8'h00, 64'h0, 64'h7777_8888_9999_AAAA, 64'h9999_AAAA);
    run_txn(1, 1'b1, 1);
    run_txn(1, 1'b1, 1);

    // Starvation: four data wins while fetch waits, then fetch is forced through
    bus.i_valid  = 1'b1;
    bus.i_addr   = 64'h8000_0020;
    bus.d_valid  = 1'b1;
    bus.d_strobe = 8'h00;
    for (int k = 0; k < 4; k++) begin
      bus.d_addr = 64'h3000 + 64'(k * 8);
      push_txn(1'b1, 64'h3000 + 64'(k * 8), MSIZE8, 8'h00, bus.d_wdata, 64'(k + 16), 64'(k + 16));
      run_txn(0, 1'b0, 1);
      checkOutput("starve_cnt_inc", 64'(dut.starve_cnt), 64'(k + 1));
    end
    push_txn(1'b0, 64'h8000_0020, MSIZE4, 8'h00, 64'h0, 64'h1234_5678_9ABC_DEF0, 64'h9ABC_DEF0);
    run_txn(1, 1'b1, 1);
    checkOutput("starve_cnt_fetch_clr", 64'(dut.starve_cnt), 64'h0);
    bus.d_addr = 64'h4000;
    push_txn(1'b1, 64'h4000, MSIZE8, 8'h00, bus.d_wdata, 64'h55, 64'h55);
    run_txn(0, 1'b1, 1);
    checkOutput("starve_cnt_alone", 64'(dut.starve_cnt), 64'h0);

    // Asynchronous reset in the middle of a fetch
    bus.i_valid = 1'b1;
    bus.i_addr  = 64'h8000_0040;
    tick();
    checkOutput("rst_pre_m_valid", 64'(bus.m_valid), 64'h1);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("rst_async_m_valid", 64'(bus.m_valid), 64'h0);
    checkOutput("rst_async_oks", 64'({bus.i_data_ok, bus.d_data_ok}), 64'h0);
    checkOutput("rst_async_state", 64'(dut.state_q), 64'(IDLE));
    checkOutput("rst_async_rdata", {bus.i_rdata, bus.d_rdata[31:0]}, 64'h0);
    bus.i_valid  = 1'b0;
    last_i_rdata = '0;
    last_d_rdata = '0;
    tick();
    reset = 1'b1;
    repeat (3) begin
      tick();
      checkOutput("rst_no_pulse", 64'({bus.i_data_ok, bus.d_data_ok, bus.m_valid}), 64'h0);
    end
    bus.i_valid = 1'b1;
    bus.i_addr  = 64'h8000_0044;
    push_txn(1'b0, 64'h8000_0044, MSIZE4, 8'h00, 64'h0, 64'hCAFE_0001_0000_0002, 64'hCAFE_0001);
    run_txn(1, 1'b1, 1);

    // Stray completion while idle must be ignored
    bus.m_data_ok = 1'b1;
    bus.m_rdata   = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.m_data_ok = 1'b0;
    checkOutput("stray_state", 64'(dut.state_q), 64'(IDLE));
    checkOutput("stray_oks", 64'({bus.i_data_ok, bus.d_data_ok, bus.m_valid}), 64'h0);
    tick();
    checkOutput("stray_oks_later", 64'({bus.i_data_ok, bus.d_data_ok, bus.m_valid}), 64'h0);
    checkOutput("stray_rdata_hold", {bus.i_rdata, bus.d_rdata[31:0]}, {last_i_rdata, last_d_rdata[31:0]});
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
